leaf_tx_packetizer: RTL

Transmit-side packetizer for one leaf output port. It accepts 32-bit words from a user kernel over the ap_vld/ap_ack handshake and wraps each word into a 49-bit BFT packet carrying destination leaf, destination port and receiver BRAM address. It enforces credit-based flow control against the receiving leaf's buffer, which returns FREESPACE_UPDATE_SIZE credits per update. It sits between a user kernel output port and the BFT injection side of a page.

---
 rtl/leaf_pkg.sv | 36 +++
 rtl/leaf_credit_counter.sv | 53 +++++
 rtl/leaf_tx_packetizer.sv | 91 +++++++++
 3 files changed

// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf transmit packetizer: packet layout,
// counter widths and FSM state encoding.
package leaf_pkg;

   localparam int PACKET_BITS           = 49;
   localparam int PAYLOAD_BITS          = 32;
   localparam int NUM_LEAF_BITS         = 5;
   localparam int NUM_PORT_BITS         = 4;
   localparam int NUM_ADDR_BITS         = 7;
   localparam int FREESPACE_UPDATE_SIZE = 64;

   // Packet field positions
   localparam int VALID_BIT = 48;
   localparam int LEAF_LSB  = 43;
   localparam int PORT_LSB  = 39;
   localparam int ADDR_LSB  = 32;

   // Credit counter holds 0..2**NUM_ADDR_BITS inclusive, hence one extra bit
   localparam int CREDIT_W = NUM_ADDR_BITS + 1;
   localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(2 ** NUM_ADDR_BITS);

   typedef struct packed {
      logic                     vld;
      logic [NUM_LEAF_BITS-1:0] leaf;
      logic [NUM_PORT_BITS-1:0] port;
      logic [NUM_ADDR_BITS-1:0] addr;
      logic [PAYLOAD_BITS-1:0]  payload;
   } pkt_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      STALL = 2'd2
   } state_e;

endpackage

// File: rtl/leaf_credit_counter.sv
// Credit tracker for the receiving leaf's buffer. Decrements on each
// captured word, adds a block of credits per return event, saturates at
// the receiver depth and flags (stickily) any attempt to exceed it.
module leaf_credit_counter
   import leaf_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                dec_i,
   input  logic                inc_i,
   input  logic                reload_i,
   output logic [CREDIT_W-1:0] credit_o,
   output logic                zero_o,
   output logic                ovf_o
);

   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                ovf_q, ovf_d;
   logic [CREDIT_W:0]   sum;

   // Next credit value: reload wins, otherwise net add/sub with saturation
   always_comb begin
      sum      = {1'b0, credit_q}
               + (inc_i ? (CREDIT_W+1)'(FREESPACE_UPDATE_SIZE) : '0)
               - (dec_i ? (CREDIT_W+1)'(1) : '0);
      credit_d = credit_q;
      ovf_d    = ovf_q;
      if (reload_i) begin
         credit_d = CREDIT_MAX;
      end else if (sum > {1'b0, CREDIT_MAX}) begin
         credit_d = CREDIT_MAX;
         ovf_d    = 1'b1;
      end else begin
         credit_d = sum[CREDIT_W-1:0];
      end
   end

   // Credit and sticky overflow registers; overflow clears only on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_q <= CREDIT_MAX;
         ovf_q    <= 1'b0;
      end else begin
         credit_q <= credit_d;
         ovf_q    <= ovf_d;
      end
   end

   assign credit_o = credit_q;
   assign zero_o   = (credit_q == '0);
   assign ovf_o    = ovf_q;

endmodule

// File: rtl/leaf_tx_packetizer.sv
// Transmit-side packetizer for one leaf output port. Wraps user words into
// BFT packets (valid, leaf, port, receiver address, payload) and throttles
// the user handshake against the receiver's credit budget.
module leaf_tx_packetizer
   import leaf_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
   input  logic [NUM_PORT_BITS-1:0] dest_port,
   input  logic [PAYLOAD_BITS-1:0]  din_user2tx,
   input  logic                     vld_user2tx,
   output logic                     ack_tx2user,
   output logic [PACKET_BITS-1:0]   dout_tx2bft,
   input  logic                     dout_ready,
   input  logic                     credit_vld,
   input  logic                     resend,
   output logic                     err_credit_ovf
);

   state_e                   state_q;
   pkt_t                     pkt_q;
   logic [NUM_ADDR_BITS-1:0] addr_q;
   logic [CREDIT_W-1:0]      credit;
   logic                     credit_zero;
   logic                     capture;

   // Capture a word only from IDLE with credit left; resend blocks it so a
   // word is never acked into a stream that is being torn down. The reset
   // term keeps ack low while reset is asserted.
   assign capture     = reset && (state_q == IDLE) && vld_user2tx
                        && !credit_zero && !resend;
   assign ack_tx2user = capture;
   assign dout_tx2bft = pkt_q;

   leaf_credit_counter u_credit (
      .clk      (clk),
      .rst_n    (reset),
      .dec_i    (capture),
      .inc_i    (credit_vld),
      .reload_i (resend),
      .credit_o (credit),
      .zero_o   (credit_zero),
      .ovf_o    (err_credit_ovf)
   );

   // Packet register, address counter and IDLE/SEND/STALL control
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pkt_q   <= '0;
         addr_q  <= '0;
      end else if (resend) begin
         // Drop any held packet; it was already acked so it is not resubmitted
         state_q <= IDLE;
         pkt_q   <= '0;
         addr_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (capture) begin
                  pkt_q.vld     <= 1'b1;
                  pkt_q.leaf    <= dest_leaf;
                  pkt_q.port    <= dest_port;
                  pkt_q.addr    <= addr_q;
                  pkt_q.payload <= din_user2tx;
                  addr_q        <= addr_q + 1'b1;
                  state_q       <= SEND;
               end else if (vld_user2tx && credit_zero) begin
                  state_q <= STALL;
               end
            end
            SEND: begin
               if (dout_ready) begin
                  pkt_q   <= '0;
                  state_q <= IDLE;
               end
            end
            STALL: begin
               if (!credit_zero) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Credit value is only consumed through the zero flag here
   logic unused_credit;
   assign unused_credit = ^credit;

endmodule
